// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Purpose  : Fetch stage between the PC logic and the decoder. Owns a
//            word-addressed fetch pointer and issues single-outstanding reads
//            to instruction memory over a req/ack handshake. Returned words
//            are buffered, tagged with their address, in a small queue. The
//            queue head is presented to decode through a valid/ready
//            handshake. A taken jump redirects the pointer, flushes the queue
//            and discards any in-flight response.
//
// Ports    : clk          - system clock, all state on rising edge
//            reset        - asynchronous, active-high, clears all state
//            jump         - redirect request, sampled on rising edge
//            jump_addr    - redirect target
//            mem_req      - read request to instruction memory
//            mem_addr     - read address, stable while mem_req is high
//            mem_ack      - memory accepted request, mem_data valid this cycle
//            mem_data     - read data
//            instr_valid  - instr/instr_pc hold a valid instruction
//            instr        - instruction word at the queue head
//            instr_pc     - address of instr
//            instr_ready  - decoder consumes head when instr_valid & instr_ready
//
// Options  : FETCH_BYPASS_EN - when defined, a response arriving in WAIT with
//            the queue empty is shown to decode in the same cycle (0-cycle
//            latency) and is not queued if decode takes it at once.
//
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
   parameter int QUEUE_DEPTH = 4,
   parameter int ADDR_WIDTH  = 16,
   parameter int DATA_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  jump,
   input  logic [ADDR_WIDTH-1:0] jump_addr,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_data,
   output logic                  instr_valid,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   input  logic                  instr_ready
);

   localparam int IW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int CW = IW + 1;

   localparam logic [CW-1:0] C_DEPTH = CW'(QUEUE_DEPTH);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_WAIT    = 2'd1;
   localparam logic [1:0] S_DISCARD = 2'd2;

   logic [1:0]            state_q,      state_d;
   logic [ADDR_WIDTH-1:0] ptr_q,        ptr_d;
   logic                  mem_req_q,    mem_req_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q,   mem_addr_d;
   logic [IW-1:0]         rd_q,         rd_d;
   logic [IW-1:0]         wr_q,         wr_d;
   logic [CW-1:0]         count_q,      count_d;
   logic [DATA_WIDTH-1:0] last_instr_q, last_instr_d;
   logic [ADDR_WIDTH-1:0] last_pc_q,    last_pc_d;

   logic [DATA_WIDTH-1:0] qdata_q [QUEUE_DEPTH];
   logic [ADDR_WIDTH-1:0] qpc_q   [QUEUE_DEPTH];

   logic                  queue_nonempty;
   logic                  queue_pop;
   logic                  queue_push;
   logic                  resp_keep;
   logic                  outstanding_after;
   logic                  bypass_valid;
   logic                  bypass_take;
   logic [ADDR_WIDTH-1:0] issue_base;

`ifdef FETCH_BYPASS_EN
   // A jump at this edge drops the response, so it must not be offered.
   assign bypass_valid = (state_q == S_WAIT) && (count_q == '0) && mem_ack && !jump;
`else
   assign bypass_valid = 1'b0;
`endif
   assign bypass_take = bypass_valid & instr_ready;

   assign queue_nonempty    = (count_q != '0);
   assign queue_pop         = queue_nonempty & instr_ready & ~jump;
   assign resp_keep         = (state_q == S_WAIT) & mem_req_q & mem_ack & ~jump;
   assign queue_push        = resp_keep & ~bypass_take;
   // True when the current request will still be pending after this edge.
   assign outstanding_after = mem_req_q & ~mem_ack;
   assign issue_base        = jump ? jump_addr : ptr_q;

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      mem_req_d    = mem_req_q;
      mem_addr_d   = mem_addr_q;
      rd_d         = rd_q;
      wr_d         = wr_q;
      count_d      = count_q;
      last_instr_d = last_instr_q;
      last_pc_d    = last_pc_q;

      // Queue pointers and occupancy after this edge's push and pop.
      if (jump) begin
         rd_d    = '0;
         wr_d    = '0;
         count_d = '0;
      end else begin
         if (queue_push) wr_d = wr_q + IW'(1);
         if (queue_pop)  rd_d = rd_q + IW'(1);
         count_d = count_q + CW'(queue_push) - CW'(queue_pop);
      end

      // Remember the last word handed to decode so instr/instr_pc hold
      // their value once the queue runs empty.
      if (queue_pop) begin
         last_instr_d = qdata_q[rd_q];
         last_pc_d    = qpc_q[rd_q];
      end else if (bypass_take) begin
         last_instr_d = mem_data;
         last_pc_d    = mem_addr_q;
      end

      // Request control. An outstanding request is never withdrawn; a jump
      // while one is pending only marks its response for discard.
      if (outstanding_after) begin
         if (jump) begin
            state_d = S_DISCARD;
            ptr_d   = jump_addr;
         end
      end else if (count_d < C_DEPTH) begin
         mem_req_d  = 1'b1;
         mem_addr_d = issue_base;
         ptr_d      = issue_base + ADDR_WIDTH'(1);
         state_d    = S_WAIT;
      end else begin
         mem_req_d = 1'b0;
         state_d   = S_IDLE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         ptr_q        <= '0;
         mem_req_q    <= 1'b0;
         mem_addr_q   <= '0;
         rd_q         <= '0;
         wr_q         <= '0;
         count_q      <= '0;
         last_instr_q <= '0;
         last_pc_q    <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         mem_req_q    <= mem_req_d;
         mem_addr_q   <= mem_addr_d;
         rd_q         <= rd_d;
         wr_q         <= wr_d;
         count_q      <= count_d;
         last_instr_q <= last_instr_d;
         last_pc_q    <= last_pc_d;
      end
   end

   // Queue storage needs no reset: occupancy alone defines which slots hold data.
   always_ff @(posedge clk) begin
      if (queue_push) begin
         qdata_q[wr_q] <= mem_data;
         qpc_q[wr_q]   <= mem_addr_q;
      end
   end

   assign mem_req     = mem_req_q;
   assign mem_addr    = mem_addr_q;
   assign instr_valid = queue_nonempty | bypass_valid;

   always_comb begin
      instr    = last_instr_q;
      instr_pc = last_pc_q;
      if (bypass_valid) begin
         instr    = mem_data;
         instr_pc = mem_addr_q;
      end else if (queue_nonempty) begin
         instr    = qdata_q[rd_q];
         instr_pc = qpc_q[rd_q];
      end
   end

endmodule
`default_nettype wire
